// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the activation datapath.
//   DEF_WIDTH / DEF_FRAC : default signed word width and fractional bit count
//   act_mode_e           : per-beat activation function selector
package fxp_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_FRAC  = 8;

    typedef enum logic [1:0] {
        ACT_IDENT  = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_LEAKY  = 2'b10,
        ACT_DLEAKY = 2'b11
    } act_mode_e;

endpackage

// File: rtl/lr_lane.sv
// One activation lane: multiply by the leak slope, shift, saturate, select, flag clipping.
// Holds the lane's S1 (product, sign) and S2 (selected result) registers; the enables come
// from the pipeline control in the top.
//   clk, rst         : clock, asynchronous active-high reset
//   s1_load, s2_load : capture stage-0 operands into S1 / S1 selection into S2
//   x, leak          : incoming lane operand and beat slope (feed the multiplier)
//   s1_mode, s1_leak : mode and slope belonging to the beat currently held in S1
//   result           : S2 register, this lane's output word
//   clip             : the S1 beat's selected result was saturated
module lr_lane
    import fxp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_load,
    input  logic             s2_load,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] leak,
    input  act_mode_e        s1_mode,
    input  logic [WIDTH-1:0] s1_leak,
    output logic [WIDTH-1:0] result,
    output logic             clip
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;

    logic signed [2*WIDTH-1:0] x_ext, leak_ext, prod_full, prod_shift;
    logic        [WIDTH:0]     prod_hi;
    logic                      prod_clip;
    logic        [WIDTH-1:0]   prod_sat;
    logic                      x_pos;

    logic [WIDTH-1:0] x_q, prod_q, result_q, sel;
    logic             x_pos_q, prod_clip_q;

    always_comb begin
        x_ext      = {{WIDTH{x[WIDTH-1]}}, x};
        leak_ext   = {{WIDTH{leak[WIDTH-1]}}, leak};
        prod_full  = x_ext * leak_ext;
        prod_shift = prod_full >>> FRAC;
        // Result fits in WIDTH bits only if every bit above the sign bit matches it.
        prod_hi    = prod_shift[2*WIDTH-1:WIDTH-1];
        prod_clip  = !((&prod_hi) || !(|prod_hi));
        if (!prod_clip) begin
            prod_sat = prod_shift[WIDTH-1:0];
        end else if (prod_shift[2*WIDTH-1]) begin
            prod_sat = SAT_MIN;
        end else begin
            prod_sat = SAT_MAX;
        end
        // Zero counts as non-positive.
        x_pos = !x[WIDTH-1] && (|x);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            x_pos_q     <= 1'b0;
            prod_q      <= '0;
            prod_clip_q <= 1'b0;
        end else if (s1_load) begin
            x_q         <= x;
            x_pos_q     <= x_pos;
            prod_q      <= prod_sat;
            prod_clip_q <= prod_clip;
        end
    end

    // A saturated product only matters when leaky mode actually picks it.
    always_comb begin
        sel  = x_q;
        clip = 1'b0;
        unique case (s1_mode)
            ACT_IDENT:  sel = x_q;
            ACT_RELU:   sel = x_pos_q ? x_q : '0;
            ACT_LEAKY: begin
                sel  = x_pos_q ? x_q : prod_q;
                clip = !x_pos_q && prod_clip_q;
            end
            ACT_DLEAKY: sel = x_pos_q ? ONE : s1_leak;
            default:    sel = x_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (s2_load) begin
            result_q <= sel;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/leaky_relu_array.sv
// LANES-wide leaky-ReLU activation block with a 2-stage valid/ready pipeline.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data, mode, leak_factor bind to the beat
//   out_valid/out_ready  : output handshake; out_data holds LANES results
//   sat_count, sat_clear : saturating count of clipped lane results, synchronous clear
module leaky_relu_array
    import fxp_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       leak_factor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [15:0]            sat_count,
    input  logic                   sat_clear
);

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    act_mode_e        s1_mode_q;
    logic [WIDTH-1:0] s1_leak_q;
    logic [15:0]      sat_count_q, sat_count_d;
    logic [16:0]      clip_total, sat_sum;
    logic [LANES-1:0] lane_clip;
    logic             s2_free, s1_move, accept;

    always_comb begin
        s2_free    = !s2_valid_q || out_ready;
        s1_move    = s1_valid_q && s2_free;
        in_ready   = !s1_valid_q || s1_move;
        accept     = in_valid && in_ready;
        s1_valid_d = accept || (s1_valid_q && !s1_move);
        s2_valid_d = s1_move || (s2_valid_q && !out_ready);
    end

    // Counted as the beat leaves S1, i.e. the edge it becomes visible on out_data.
    always_comb begin
        clip_total = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            clip_total = clip_total + 17'(lane_clip[i]);
        end
        sat_sum     = {1'b0, sat_count_q} + clip_total;
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (s1_move) begin
            sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_mode_q   <= ACT_IDENT;
            s1_leak_q   <= '0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            sat_count_q <= sat_count_d;
            if (accept) begin
                s1_mode_q <= act_mode_e'(mode);
                s1_leak_q <= leak_factor;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lr_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .s1_load (accept),
            .s2_load (s1_move),
            .x       (in_data[i*WIDTH +: WIDTH]),
            .leak    (leak_factor),
            .s1_mode (s1_mode_q),
            .s1_leak (s1_leak_q),
            .result  (out_data[i*WIDTH +: WIDTH]),
            .clip    (lane_clip[i])
        );
    end

    assign out_valid = s2_valid_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_leaky_relu_array.sv
module tb_leaky_relu_array;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, sat_clear;
    logic [63:0] in_data, out_data;
    logic [1:0]  mode;
    logic [15:0] leak_factor, sat_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    leaky_relu_array #(
        .LANES (4),
        .WIDTH (16),
        .FRAC  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mode        (mode),
        .leak_factor (leak_factor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sat_count   (sat_count),
        .sat_clear   (sat_clear)
    );

    // Reference: exact product, floor division by 2^8, clamp to the 16-bit range.
    function automatic logic [15:0] ref_lane(input logic [1:0] m, input logic signed [15:0] x,
                                             input logic signed [15:0] lk, output int clip);
        longint p, q;
        logic [15:0] r;
        p = longint'(x) * longint'(lk);
        q = p / 256;
        if (p < 0 && q * 256 != p) q = q - 1;
        clip = 0;
        case (m)
            2'd0: r = x;
            2'd1: r = (x > 0) ? x : 16'h0000;
            2'd2: begin
                if (x > 0) r = x;
                else if (q > 32767) begin r = 16'h7FFF; clip = 1; end
                else if (q < -32768) begin r = 16'h8000; clip = 1; end
                else r = q[15:0];
            end
            default: r = (x > 0) ? 16'h0100 : lk;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ref_beat(input logic [1:0] m, input logic [63:0] d,
                                             input logic [15:0] lk, output int nclip);
        logic [63:0] r;
        int c;
        nclip = 0;
        for (int i = 0; i < 4; i++) begin
            r[i*16 +: 16] = ref_lane(m, d[i*16 +: 16], lk, c);
            nclip += c;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] rand_beat();
        return {rand_word(), rand_word(), rand_word(), rand_word()};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 2'b00; leak_factor = '0;
        out_ready = 1'b0; sat_clear = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++;
            $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (sat_count !== 16'h0) begin errors++;
            $display("FAIL reset_sat_count got=%h want=0", sat_count); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL post_reset in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    // Single beat with out_ready high: absent after one edge, present after the second.
    task automatic test_vector(input string name, input logic [1:0] m, input logic [15:0] lk,
                               input logic [63:0] d, input logic [63:0] want);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d; mode = m; leak_factor = lk;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL %s_early_valid got=%b want=0", name, out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== want) begin errors++;
            $display("FAIL %s got valid=%b data=%h want valid=1 data=%h", name, out_valid,
                     out_data, want); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        sat_clear = 1'b1; @(posedge clk); #1 sat_clear = 1'b0;
        checks++; if (sat_count !== 16'h0) begin errors++;
            $display("FAIL sat_clear got=%h want=0", sat_count); end
        test_vector("sat_leaky", 2'b10, 16'h7FFF, 64'h8000_FFFF_0100_8000, 64'h8000_FF80_0100_8000);
        checks++; if (sat_count !== 16'd2) begin errors++;
            $display("FAIL sat_count_two got=%0d want=2", sat_count); end
        test_vector("sat_deriv", 2'b11, 16'h7FFF, 64'h8000_FFFF_0100_8000, 64'h7FFF_7FFF_0100_7FFF);
        checks++; if (sat_count !== 16'd2) begin errors++;
            $display("FAIL sat_count_deriv got=%0d want=2", sat_count); end
        // Clear lands on the same edge the clipping beat moves into S2.
        in_valid = 1'b1; in_data = 64'h8000_FFFF_0100_8000; mode = 2'b10; leak_factor = 16'h7FFF;
        @(posedge clk); #1 in_valid = 1'b0; sat_clear = 1'b1;
        @(posedge clk); #1 sat_clear = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 64'h8000_FF80_0100_8000) begin errors++;
            $display("FAIL sat_clear_beat got=%h want=8000ff8001008000", out_data); end
        checks++; if (sat_count !== 16'h0) begin errors++;
            $display("FAIL sat_clear_priority got=%0d want=0", sat_count); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d[8], exp_q[$], prev_data, want;
        logic [15:0] lk[8];
        logic [1:0]  m[8];
        int sent = 0, got = 0, clips = 0, c, cycles = 0;
        bit prev_stall = 0, exp_rdy;
        for (int i = 0; i < 8; i++) begin
            d[i] = rand_beat(); lk[i] = rand_word(); m[i] = 2'($urandom_range(0, 3));
        end
        out_ready = 1'b1; sat_clear = 1'b1;
        @(posedge clk); #1 sat_clear = 1'b0;
        in_valid = 1'b1; in_data = d[0]; mode = m[0]; leak_factor = lk[0];
        out_ready = 1'($urandom_range(0, 1));
        while (got < 8 && cycles < 200) begin
            cycles++;
            @(negedge clk);
            exp_rdy = !(exp_q.size() >= 2 && !out_ready);
            checks++; if (in_ready !== exp_rdy) begin errors++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cycles, in_ready, exp_rdy); end
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin errors++;
                    $display("FAIL b2b_stall_hold got=%b/%h want=1/%h", out_valid, out_data,
                             prev_data); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++;
                    $display("FAIL b2b_spurious got=%h want=no beat", out_data);
                end else begin
                    want = exp_q.pop_front();
                    if (out_data !== want) begin errors++;
                        $display("FAIL b2b_data beat=%0d got=%h want=%h", got, out_data, want); end
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_beat(m[sent], d[sent], lk[sent], c));
                clips += c;
                sent++;
            end
            @(posedge clk); #1;
            if (sent < 8) begin
                in_valid = 1'b1; in_data = d[sent]; mode = m[sent]; leak_factor = lk[sent];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 8) begin errors++;
            $display("FAIL b2b_count got=%0d want=8", got); end
        checks++; if (sat_count !== 16'(clips)) begin errors++;
            $display("FAIL b2b_sat_count got=%0d want=%0d", sat_count, clips); end
    endtask

    task automatic test_mode_rotate();
        localparam int N = 12;
        logic [63:0] d[N], want[N];
        logic [15:0] lk[N];
        int clips = 0, c;
        for (int i = 0; i < N; i++) begin
            d[i] = rand_beat(); lk[i] = rand_word();
            want[i] = ref_beat(2'(i % 4), d[i], lk[i], c);
            clips += c;
        end
        out_ready = 1'b1; sat_clear = 1'b1;
        @(posedge clk); #1 sat_clear = 1'b0;
        in_valid = 1'b1; in_data = d[0]; mode = 2'd0; leak_factor = lk[0];
        for (int j = 0; j <= N; j++) begin
            @(posedge clk); #1;
            if (j == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++;
                    $display("FAIL rot_first_valid got=%b want=0", out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1 || out_data !== want[j-1]) begin errors++;
                    $display("FAIL rot_beat%0d got=%b/%h want=1/%h", j - 1, out_valid, out_data,
                             want[j-1]); end
            end
            checks++; if (in_ready !== 1'b1) begin errors++;
                $display("FAIL rot_throughput cyc=%0d got=%b want=1", j, in_ready); end
            if (j + 1 < N) begin
                in_data = d[j+1]; mode = 2'((j + 1) % 4); leak_factor = lk[j+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++; if (sat_count !== 16'(clips)) begin errors++;
            $display("FAIL rot_sat_count got=%0d want=%0d", sat_count, clips); end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] d, want;
        int c;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h1111_2222_3333_4444; mode = 2'b00; leak_factor = 16'h0019;
        @(posedge clk); #1 in_data = 64'h5555_6666_7777_0808;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("FAIL mid_full got valid=%b ready=%b want 1/0", out_valid, in_ready); end
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async got valid=%b data=%h ready=%b want 0/0/1", out_valid,
                     out_data, in_ready); end
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++;
                $display("FAIL mid_stale cyc=%0d got=%b want=0", i, out_valid); end
        end
        d = 64'hFF00_0000_8000_0123;
        want = ref_beat(2'b01, d, 16'h0040, c);
        test_vector("mid_after", 2'b01, 16'h0040, d, want);
    endtask

    task automatic test_sat_sticky();
        localparam int NB = 16390;
        int want;
        want = (4 * NB > 65535) ? 65535 : 4 * NB;
        out_ready = 1'b1; sat_clear = 1'b1;
        @(posedge clk); #1 sat_clear = 1'b0;
        in_valid = 1'b1; in_data = 64'h8000_8000_8000_8000; mode = 2'b10; leak_factor = 16'h7FFF;
        repeat (NB) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sat_count !== 16'(want)) begin errors++;
            $display("FAIL sat_sticky got=%h want=%h", sat_count, 16'(want)); end
        sat_clear = 1'b1; @(posedge clk); #1 sat_clear = 1'b0;
        checks++; if (sat_count !== 16'h0) begin errors++;
            $display("FAIL sat_sticky_clear got=%h want=0", sat_count); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_vector("leaky_vec", 2'b10, 16'h0019, 64'h7FFF_0000_FE00_0200, 64'h7FFF_0000_FFCE_0200);
        test_vector("deriv_vec", 2'b11, 16'h0019, 64'h0001_0000_FF00_0100, 64'h0100_0019_0019_0100);
        test_vector("relu_vec", 2'b01, 16'h0019, 64'h0001_0000_FF00_8000, 64'h0001_0000_0000_0000);
        test_saturation();
        test_back_to_back();
        test_mode_rotate();
        test_reset_midflight();
        test_sat_sticky();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leaky_relu_array.md
LEAKY_RELU_ARRAY -- requirements
Module: leaky_relu_array

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel activation lanes.
REQ-002 SHALL have parameter WIDTH, default 16: signed fixed-point word width.
REQ-003 SHALL have parameter FRAC, default 8: fractional bits, so 1.0 = 2^FRAC.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: input beat valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, LANES*WIDTH: signed lanes, lane i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port mode, input, 2: 00 identity, 01 ReLU, 10 leaky ReLU, 11 leaky-ReLU derivative; sampled with each beat.
REQ-010 SHALL have port leak_factor, input, WIDTH: signed Q(WIDTH-FRAC).FRAC slope; sampled with each beat.
REQ-011 SHALL have port out_valid, output, 1: output beat valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts a beat.
REQ-013 SHALL have port out_data, output, LANES*WIDTH: result lanes, same packing as in_data.
REQ-014 SHALL have port sat_count, output, 16: saturating count of lane results clipped.
REQ-015 SHALL have port sat_clear, input, 1: synchronous clear of sat_count.

Function
REQ-016 SHALL accept a beat when in_valid && in_ready; mode and leak_factor bind to that beat.
REQ-017 SHALL use a 2-stage pipeline: S1 registers lane products and sign flags, S2 registers selected results; latency exactly 2 cycles with out_ready held high.
REQ-018 SHALL advance each stage when it is empty or the downstream stage advances in the same cycle; in_ready = S1 empty or S1 advancing.
REQ-019 SHALL sustain one beat per cycle when out_ready is constantly high.
REQ-020 SHALL hold out_valid and out_data stable while out_valid && !out_ready; no beat dropped or duplicated.
REQ-021 SHALL compute product = in * leak_factor at full 2*WIDTH precision, arithmetic-shift right by FRAC (truncation toward minus infinity), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-022 SHALL produce per lane: identity -> x; ReLU -> x>0 ? x : 0; leaky -> x>0 ? x : product; derivative -> x>0 ? 2^FRAC : leak_factor.
REQ-023 SHALL treat x == 0 as non-positive (leaky gives product = 0, derivative gives leak_factor).
REQ-024 SHALL increment sat_count by the number of lanes whose selected result was clipped, when that beat leaves S1 into S2, sticking at 16'hFFFF.
REQ-025 SHALL give sat_clear priority over a same-cycle increment (result 0).
REQ-026 SHALL treat lanes independently; no cross-lane state.

Reset
REQ-027 SHALL on rst asynchronously clear both stage valids, out_valid=0, out_data=0, sat_count=0.
REQ-028 SHALL drive in_ready=1 during and after reset.
REQ-029 SHALL discard all in-flight beats when rst asserts mid-operation; first beat after release appears 2 cycles after acceptance.

Structure
REQ-030 SHALL take the mode enum (ACT_IDENT, ACT_RELU, ACT_LEAKY, ACT_DLEAKY) and default WIDTH/FRAC constants from a shared package fxp_pkg.
REQ-031 SHALL instantiate one sub-module lr_lane per lane (multiply, shift, saturate, select, clip flag); pipeline control and counter live in the top.

Verification
REQ-032 SHALL cover: WIDTH=16, FRAC=8, mode=10, leak=0x0019 (~0.1), lanes {0x0200, 0xFE00, 0x0000, 0x7FFF} -> {0x0200, 0xFFCE, 0x0000, 0x7FFF} two cycles later.
REQ-033 SHALL cover: mode=11, leak=0x0019, lanes {0x0100, 0xFF00, 0x0000, 0x0001} -> {0x0100, 0x0019, 0x0019, 0x0100}.
REQ-034 SHALL cover: mode=10, leak=0x7FFF, lane 0x8000 -> 0x8000 with saturation, sat_count increments by 1 per clipped lane; sat_clear with same-cycle clip -> 0.
REQ-035 SHALL cover: 8 back-to-back beats, out_ready toggled 0/1 pseudo-randomly -> all 8 outputs in order, stable while stalled, in_ready low only when both stages full and stalled.
REQ-036 SHALL cover: rst asserted with 2 beats in flight -> out_valid falls immediately, no stale beat emitted after release.
REQ-037 SHALL cover: mode changes every beat (00,01,10,11) at full throughput -> each output uses its own beat's mode and leak_factor.
